// File: rtl/dict_pkg.sv
// Shared types and helpers for the dictionary encoder: slot and entry layouts,
// the probe-start hash and the reserved overflow id.
package dict_pkg;

    typedef logic [31:0] value_t;
    typedef logic [15:0] id_t;

    localparam int LOG_TABLE_SIZE = 10;
    localparam int TABLE_SIZE     = 1 << LOG_TABLE_SIZE;

    typedef logic [LOG_TABLE_SIZE-1:0] addr_t;

    typedef struct packed {
        value_t value;
        id_t    id;
    } entry_t;

    typedef struct packed {
        logic   used;
        value_t value;
        id_t    id;
    } slot_t;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        PROBE,
        EMIT
    } state_t;

    function automatic id_t overflow_id();
        return '1;
    endfunction

    // Fold the value in LOG_TABLE_SIZE-bit chunks; the top chunk is zero-padded.
    function automatic addr_t dict_hash(input value_t value);
        addr_t h;
        h = '0;
        for (int i = 0; i < $bits(value_t); i += LOG_TABLE_SIZE) begin
            h ^= addr_t'(value >> i);
        end
        return h;
    endfunction

endpackage

// File: rtl/data_i.sv
// Valid/ready stream bundle with keep and last sidebands, parameterised on payload type.
interface data_i #(
    parameter type T = logic [31:0]
);
    T     data;
    logic keep;
    logic last;
    logic valid;
    logic ready;

    modport m (output data, output keep, output last, output valid, input ready);
    modport s (input data, input keep, input last, input valid, output ready);
endinterface

// File: rtl/dict_slot_ram.sv
// Hash-table slot storage: one write port, one read port, registered read data.
module dict_slot_ram
    import dict_pkg::*;
(
    input  logic  clk,
    input  logic  we,
    input  addr_t waddr,
    input  slot_t wdata,
    input  addr_t raddr,
    output slot_t rdata
);

    slot_t mem [TABLE_SIZE];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/dictionary_encoder.sv
// Single-lane dictionary encoder: assigns dense ids to distinct values via a linear-probe hash table.
// Optional statistics counters are enabled with the DICT_ENCODER_STATS_EN macro.
module dictionary_encoder
    import dict_pkg::*;
#(
    parameter int MAX_IDS = TABLE_SIZE
) (
    input  logic        clk,
    input  logic        rst,
    data_i.s            in,
    data_i.m            out_ids,
    data_i.m            out_entries,
`ifdef DICT_ENCODER_STATS_EN
    output logic [31:0] stat_hits,
    output logic [31:0] stat_inserts,
    output logic [31:0] stat_probes,
`endif
    output logic        overflow
);

    localparam id_t ID_LIMIT = id_t'(MAX_IDS);

    state_t state;
    addr_t  clr_addr;
    addr_t  addr;
    addr_t  probe_cnt;
    id_t    next_id;

    value_t cur_value;
    logic   cur_keep;
    logic   cur_last;

    logic   ids_valid;
    id_t    ids_data;
    logic   ids_keep;
    logic   ids_last;
    logic   ent_valid;
    entry_t ent_data;
    logic   ent_keep;
    logic   ent_last;

    logic   we;
    addr_t  waddr;
    addr_t  raddr;
    slot_t  wdata;
    slot_t  rdata;

    logic   hit;
    logic   can_insert;
    logic   probe_more;
    id_t    probe_id;
    logic   emit_done;
    logic   restart;

    // The read address is combinational so the slot data is ready in the cycle after it is issued.
    always_comb begin
        raddr      = (state == PROBE) ? addr + addr_t'(1) : dict_hash(in.data);
        we         = 1'b0;
        waddr      = addr;
        wdata      = '{used: 1'b1, value: cur_value, id: next_id};
        hit        = rdata.used && (rdata.value == cur_value);
        can_insert = !rdata.used && (next_id < ID_LIMIT);
        probe_more = rdata.used && !hit && (probe_cnt != addr_t'(TABLE_SIZE - 1));
        probe_id   = hit ? rdata.id : (can_insert ? next_id : overflow_id());
        emit_done  = (!ids_valid || out_ids.ready) && (!ent_valid || out_entries.ready);
        restart    = (state == EMIT) && emit_done && cur_last;
        if (state == CLEAR) begin
            we    = 1'b1;
            waddr = clr_addr;
            wdata = '0;
        end else if (state == PROBE) begin
            we = can_insert;
        end
    end

    dict_slot_ram u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    assign in.ready          = (state == IDLE);
    assign out_ids.valid     = ids_valid;
    assign out_ids.data      = ids_data;
    assign out_ids.keep      = ids_keep;
    assign out_ids.last      = ids_last;
    assign out_entries.valid = ent_valid;
    assign out_entries.data  = ent_data;
    assign out_entries.keep  = ent_keep;
    assign out_entries.last  = ent_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= CLEAR;
            clr_addr  <= '0;
            addr      <= '0;
            probe_cnt <= '0;
            next_id   <= '0;
            overflow  <= 1'b0;
            cur_value <= '0;
            cur_keep  <= 1'b0;
            cur_last  <= 1'b0;
            ids_valid <= 1'b0;
            ids_data  <= '0;
            ids_keep  <= 1'b0;
            ids_last  <= 1'b0;
            ent_valid <= 1'b0;
            ent_data  <= '0;
            ent_keep  <= 1'b0;
            ent_last  <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_addr <= clr_addr + addr_t'(1);
                    if (clr_addr == addr_t'(TABLE_SIZE - 1)) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (in.valid) begin
                        cur_value <= in.data;
                        cur_keep  <= in.keep;
                        cur_last  <= in.last;
                        if (!in.keep) begin
                            ids_valid <= 1'b1;
                            ids_data  <= '0;
                            ids_keep  <= 1'b0;
                            ids_last  <= in.last;
                            ent_valid <= in.last;
                            ent_data  <= '{value: in.data, id: '0};
                            ent_keep  <= 1'b0;
                            ent_last  <= in.last;
                            state     <= EMIT;
                        end else begin
                            addr      <= dict_hash(in.data);
                            probe_cnt <= '0;
                            state     <= PROBE;
                        end
                    end
                end
                PROBE: begin
                    if (probe_more) begin
                        addr      <= addr + addr_t'(1);
                        probe_cnt <= probe_cnt + addr_t'(1);
                    end else begin
                        ids_valid <= 1'b1;
                        ids_data  <= probe_id;
                        ids_keep  <= cur_keep;
                        ids_last  <= cur_last;
                        ent_valid <= can_insert || cur_last;
                        ent_data  <= '{value: cur_value, id: probe_id};
                        ent_keep  <= can_insert;
                        ent_last  <= cur_last;
                        if (can_insert) begin
                            next_id <= next_id + id_t'(1);
                        end
                        if (!hit && !can_insert) begin
                            overflow <= 1'b1;
                        end
                        state <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ids.ready) begin
                        ids_valid <= 1'b0;
                    end
                    if (out_entries.ready) begin
                        ent_valid <= 1'b0;
                    end
                    // A last beat closes the dictionary: wipe the table and start ids over.
                    if (restart) begin
                        state    <= CLEAR;
                        clr_addr <= '0;
                        next_id  <= '0;
                        overflow <= 1'b0;
                    end else if (emit_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

`ifdef DICT_ENCODER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_hits    <= '0;
            stat_inserts <= '0;
            stat_probes  <= '0;
        end else if (restart) begin
            stat_hits    <= '0;
            stat_inserts <= '0;
            stat_probes  <= '0;
        end else if (state == PROBE) begin
            if (hit && stat_hits != '1) begin
                stat_hits <= stat_hits + 32'd1;
            end
            if (can_insert && stat_inserts != '1) begin
                stat_inserts <= stat_inserts + 32'd1;
            end
            if (probe_more && stat_probes != '1) begin
                stat_probes <= stat_probes + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dictionary_encoder.sv
// Scoreboard bench for dictionary_encoder: directed beats push expected ids/entries,
// an independent monitor pops and compares them at each output handshake.
module tb_dictionary_encoder;
    import dict_pkg::*;

    typedef struct {
        id_t  id;
        logic keep;
        logic last;
        int   lat;
    } exp_id_t;

    typedef struct {
        entry_t e;
        logic   keep;
        logic   last;
    } exp_ent_t;

    logic clk = 1'b0;
    logic rst;
    logic overflow;
`ifdef DICT_ENCODER_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_inserts;
    logic [31:0] stat_probes;
`endif

    data_i #(.T(value_t)) in_if ();
    data_i #(.T(id_t))    ids_if ();
    data_i #(.T(entry_t)) ent_if ();

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int hs_q[$];
    exp_id_t  exp_ids[$];
    exp_ent_t exp_ents[$];
    logic ids_seen = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dictionary_encoder #(.MAX_IDS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in          (in_if),
        .out_ids     (ids_if),
        .out_entries (ent_if),
`ifdef DICT_ENCODER_STATS_EN
        .stat_hits    (stat_hits),
        .stat_inserts (stat_inserts),
        .stat_probes  (stat_probes),
`endif
        .overflow    (overflow)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic recordFail(input string msg);
        checks++;
        $display("[TB] FAIL %s", msg);
    endtask

    // Drive one beat and queue what the encoder must answer for it.
    task automatic applyStimulus(input value_t v, input logic keep, input logic last,
                                 input id_t eid, input logic enew, input int lat);
        exp_id_t  xi;
        exp_ent_t xe;
        int n;
        xi.id = eid; xi.keep = keep; xi.last = last; xi.lat = lat;
        exp_ids.push_back(xi);
        if (enew || last) begin
            xe.e.value = v; xe.e.id = eid; xe.keep = enew; xe.last = last;
            exp_ents.push_back(xe);
        end
        @(negedge clk);
        in_if.data = v; in_if.keep = keep; in_if.last = last; in_if.valid = 1'b1;
        n = 0;
        while (!in_if.ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!in_if.ready) begin
            recordFail($sformatf("handshake_timeout: value 0x%0h never accepted", v));
            in_if.valid = 1'b0;
            return;
        end
        hs_q.push_back(cyc);
        @(posedge clk);
        #1 in_if.valid = 1'b0;
    endtask

    task automatic waitReady(output int n);
        n = 0;
        while (!in_if.ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!in_if.ready) recordFail("ready_timeout: in.ready never rose");
    endtask

    // Monitor: compares latency at first valid and contents at each handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (ids_if.valid && !ids_seen) begin
                ids_seen = 1'b1;
                if (hs_q.size() > 0) begin
                    int hs;
                    hs = hs_q.pop_front();
                    if (exp_ids.size() > 0 && exp_ids[0].lat >= 0)
                        checkOutput("id_latency", 64'(cyc - hs), 64'(exp_ids[0].lat));
                end
            end
            if (ids_if.valid && ids_if.ready) begin
                ids_seen = 1'b0;
                if (exp_ids.size() == 0) begin
                    recordFail($sformatf("ids_unexpected: got id 0x%0h, required none", ids_if.data));
                end else begin
                    exp_id_t xi;
                    xi = exp_ids.pop_front();
                    checkOutput("id", 64'({ids_if.data, ids_if.keep, ids_if.last}),
                                64'({xi.id, xi.keep, xi.last}));
                end
            end
            if (ent_if.valid && ent_if.ready) begin
                if (exp_ents.size() == 0) begin
                    recordFail($sformatf("entry_unexpected: got 0x%0h, required none", ent_if.data));
                end else begin
                    exp_ent_t xe;
                    xe = exp_ents.pop_front();
                    if (xe.keep)
                        checkOutput("entry", 64'({ent_if.data, ent_if.keep, ent_if.last}),
                                    64'({xe.e, xe.keep, xe.last}));
                    else
                        checkOutput("entry_last_only", 64'({ent_if.keep, ent_if.last}),
                                    64'({xe.keep, xe.last}));
                end
            end
        end
    end

    initial begin
        int n;
        logic any_valid;
        rst = 1'b1;
        in_if.valid = 1'b0; in_if.data = '0; in_if.keep = 1'b0; in_if.last = 1'b0;
        ids_if.ready = 1'b1;
        ent_if.ready = 1'b1;

        repeat (3) @(negedge clk);
        checkOutput("reset_in_ready", 64'(in_if.ready), 64'd0);
        checkOutput("reset_ids_valid", 64'(ids_if.valid), 64'd0);
        checkOutput("reset_ent_valid", 64'(ent_if.valid), 64'd0);
        checkOutput("reset_overflow", 64'(overflow), 64'd0);
        rst = 1'b0;

        n = 0;
        any_valid = 1'b0;
        while (!in_if.ready && n < 3000) begin
            @(negedge clk);
            n++;
            any_valid |= ids_if.valid | ent_if.valid;
        end
        checkOutput("clear_ready_cycle", 64'(n), 64'(TABLE_SIZE));
        checkOutput("clear_outputs_idle", 64'(any_valid), 64'd0);

        // Basic dictionary build.
        applyStimulus(32'd7, 1'b1, 1'b0, 16'd0, 1'b1, 2);
        applyStimulus(32'd9, 1'b1, 1'b0, 16'd1, 1'b1, 2);
        applyStimulus(32'd7, 1'b1, 1'b0, 16'd0, 1'b0, 2);
        applyStimulus(32'd9, 1'b1, 1'b0, 16'd1, 1'b0, 2);
        applyStimulus(32'd3, 1'b1, 1'b1, 16'd2, 1'b1, 2);
        waitReady(n);
        checkOutput("clear_before_accept", 64'(n > TABLE_SIZE), 64'd1);
        checkOutput("overflow_idle", 64'(overflow), 64'd0);

        // Collision at slot 5, and collision at the last slot wrapping to slot 0.
        applyStimulus(32'd5,          1'b1, 1'b0, 16'd0, 1'b1, 2);
        applyStimulus(32'h0010_0405,  1'b1, 1'b0, 16'd1, 1'b1, 3);
        applyStimulus(32'd5,          1'b1, 1'b0, 16'd0, 1'b0, 2);
        applyStimulus(32'h0010_0405,  1'b1, 1'b1, 16'd1, 1'b0, 3);
        applyStimulus(32'h0000_03FF,  1'b1, 1'b0, 16'd0, 1'b1, 2);
        applyStimulus(32'h0010_07FF,  1'b1, 1'b0, 16'd1, 1'b1, 3);
        applyStimulus(32'h0000_03FF,  1'b1, 1'b0, 16'd0, 1'b0, 2);
        applyStimulus(32'h0010_07FF,  1'b1, 1'b1, 16'd1, 1'b0, 3);

        // keep=0 beats never insert or consume an id.
        applyStimulus(32'd20, 1'b1, 1'b0, 16'd0, 1'b1, 2);
        applyStimulus(32'd99, 1'b0, 1'b0, 16'd0, 1'b0, -1);
        applyStimulus(32'd21, 1'b1, 1'b0, 16'd1, 1'b1, 2);
        applyStimulus(32'd99, 1'b1, 1'b0, 16'd2, 1'b1, 2);
        applyStimulus(32'd0,  1'b0, 1'b1, 16'd0, 1'b0, -1);

        // Entry backpressure while the id side completes.
        waitReady(n);
        @(posedge clk);
        #1 ent_if.ready = 1'b0;
        applyStimulus(32'd10, 1'b1, 1'b0, 16'd0, 1'b1, 2);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp_ent_valid", 64'(ent_if.valid), 64'd1);
            checkOutput("bp_ent_stable", 64'(ent_if.data), 64'({32'd10, 16'd0}));
            checkOutput("bp_in_ready", 64'(in_if.ready), 64'd0);
        end
        checkOutput("bp_ids_done", 64'(ids_if.valid), 64'd0);
        @(posedge clk);
        #1 ent_if.ready = 1'b1;
        applyStimulus(32'd11, 1'b1, 1'b1, 16'd1, 1'b1, 2);

        // Id exhaustion with MAX_IDS=4.
        applyStimulus(32'd1, 1'b1, 1'b0, 16'd0, 1'b1, 2);
        applyStimulus(32'd2, 1'b1, 1'b0, 16'd1, 1'b1, 2);
        applyStimulus(32'd3, 1'b1, 1'b0, 16'd2, 1'b1, 2);
        applyStimulus(32'd4, 1'b1, 1'b0, 16'd3, 1'b1, 2);
        checkOutput("overflow_before", 64'(overflow), 64'd0);
        applyStimulus(32'd5, 1'b1, 1'b0, 16'hFFFF, 1'b0, 2);
        repeat (3) @(negedge clk);
        checkOutput("overflow_set", 64'(overflow), 64'd1);
        applyStimulus(32'd1, 1'b1, 1'b0, 16'd0, 1'b0, 2);
        repeat (3) @(negedge clk);
        checkOutput("overflow_sticky", 64'(overflow), 64'd1);
        applyStimulus(32'd6, 1'b1, 1'b1, 16'hFFFF, 1'b0, 2);
        waitReady(n);
        checkOutput("overflow_cleared", 64'(overflow), 64'd0);

        n = 0;
        while ((exp_ids.size() != 0 || exp_ents.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ids_drained", 64'(exp_ids.size()), 64'd0);
        checkOutput("entries_drained", 64'(exp_ents.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/dictionary_encoder.md
Name: dictionary_encoder

Overview:
- Inverse of the dictionary materializer: streams column values and assigns each distinct value a dense id (0, 1, 2, ...).
- Emits one id per input beat, plus a (value, id) entry stream for every newly inserted value, so the decode side can ingest it as its value column.
- Single lane with one hash-table bank. Wider instances replicate it behind a crossbar.

Parameters:
- value_t, logic[31:0], column value type.
- id_t, logic[15:0], dense id type; all-ones is reserved as OVERFLOW_ID.
- LOG_TABLE_SIZE, 10, log2 of hash-table slots. Must be ≤ $bits(id_t).
- MAX_IDS, 2**LOG_TABLE_SIZE, id capacity. Must be ≤ 2**LOG_TABLE_SIZE and < 2**$bits(id_t).

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- in, data_i.s #(value_t), -, input values: data, keep, last, valid, ready.
- out_ids, data_i.m #(id_t), -, id per input beat; keep and last forwarded.
- out_entries, data_i.m #(entry_t), -, new dictionary entries {value, id}.
- overflow, out, 1, sticky; set when an insert failed.

Behaviour:
- Reset values: out_ids.valid=0, out_entries.valid=0, in.ready=0, overflow=0, next_id=0. FSM enters CLEAR.
- Slot RAM: TABLE_SIZE entries of {used, value, id}, with 1-cycle synchronous read.
- CLEAR:
  - Writes used=0 to slot addr, one slot per cycle, for TABLE_SIZE cycles.
  - Then goes to IDLE; in.ready=1 only in IDLE.
  - rst asserted at any point restarts CLEAR from slot 0.
- IDLE:
  - On in.valid&&in.ready, latch the beat.
  - If keep=0: go straight to EMIT with id=0 and keep=0; no lookup.
  - Otherwise issue a read at addr=hash(value) and go to PROBE; probe_cnt=0.
- PROBE (data from the previous read is present):
  - used && value match: hit; id=slot.id; go to EMIT.
  - !used && next_id<MAX_IDS: write {1, value, next_id}; id=next_id; next_id++; new=1; go to EMIT.
  - !used && next_id==MAX_IDS: id=OVERFLOW_ID; overflow=1; go to EMIT.
  - used && mismatch: addr=(addr+1) mod TABLE_SIZE (wraps); probe_cnt++; issue the read and stay in PROBE.
  - probe_cnt reaching TABLE_SIZE-1 without a hit or free slot: treat as overflow, as above.
- Latency: home-slot hit gives out_ids.valid 2 cycles after the input handshake; each extra probe adds 1 cycle.
- EMIT:
  - out_ids.valid=1.
  - out_entries.valid=1 if new, or if the beat carried last. A last-only entry has keep=0.
  - Each output completes its handshake independently, tracked with a sent flag. valid holds until ready.
  - Go to IDLE when both are done; a last beat goes to CLEAR instead, which also resets next_id=0 and overflow=0.
- Throughput: at most one beat per 3 cycles (IDLE→PROBE→EMIT). No overlap between beats.
- Simultaneous events: out_ids and out_entries may handshake in the same cycle or in different cycles; the order between them is free.

Optional Feature:
- Macro DICT_ENCODER_STATS_EN.
- Defined: adds outputs stat_hits[31:0], stat_inserts[31:0] and stat_probes[31:0].
  - These are saturating counters of hits, inserts and extra probe cycles.
  - They are cleared by rst and on entry to CLEAR.
- Undefined: the ports and counters are absent; functional behaviour is identical.

Decomposition:
- dict_pkg holds:
  - entry_t struct {value, id}.
  - slot_t struct {used, value, id}.
  - Function dict_hash(value) = XOR fold of the value into LOG_TABLE_SIZE bits.
  - OVERFLOW_ID constant function.
- Sub-module dict_slot_ram: simple dual-port RAM, 1 write and 1 read port, 1-cycle read latency, no reset.
- dictionary_encoder contains the FSM, counters and handshake logic.

Test Plan:
- Reset, then wait TABLE_SIZE cycles → in.ready rises exactly at cycle 1024 after rst deassertion; all outputs stay invalid.
- Values 7, 9, 7, 9, 3 (last on 3) → ids 0, 1, 0, 1, 2. Entries are {7,0}, {9,1}, {3,2}; the entry with {3,2} has last=1. The following beats are accepted only after a new CLEAR.
- Two values with equal dict_hash, 5 then the colliding one, then both repeated → ids 0, 1, 0, 1. The second lookup of the colliding value takes 3 cycles to out_ids.valid. Include a case that places the home slot at TABLE_SIZE-1 to check wrap to slot 0.
- MAX_IDS=4: distinct values 1..5 → ids 0..3, then OVERFLOW_ID 0xFFFF; overflow=1 and stays high until last/CLEAR. Only 4 entries are emitted.
- Backpressure: out_entries.ready=0 for 10 cycles on a new value → out_ids handshakes once, the entry stays valid and stable, in.ready stays 0 until the entry handshakes.
- keep=0 beat with last=1 → out_ids keep=0 last=1; out_entries emits keep=0 last=1; no insert, next_id unchanged before CLEAR.
